// File: rtl/pll_phase_stepper_if.sv
// Request/status bundle between the PMD register wrapper and pll_phase_stepper.
// The wrapper uses the master modport and the stepper uses the slave modport.
`timescale 1ns/1ps

interface pll_phase_stepper_if #(
    parameter int POS_WIDTH = 8
);
    logic                 step_req;
    logic [15:0]          step_count;
    logic                 step_up;
    logic [2:0]           counter_sel;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [15:0]          steps_left;
    logic [POS_WIDTH-1:0] phase_pos;

    modport master (
        output step_req, step_count, step_up, counter_sel,
        input  busy, done, error, steps_left, phase_pos
    );

    modport slave (
        input  step_req, step_count, step_up, counter_sel,
        output busy, done, error, steps_left, phase_pos
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// Drives the PLL dynamic phase-shift handshake (phasestep/phasedone), one step at a time, and tracks phase.
// Optional macro PHASE_STEP_ABORT_EN adds abort_req, which ends a move once the in-flight step completes.
`timescale 1ns/1ps

module pll_phase_stepper #(
    parameter int STEPS_PER_PERIOD = 64,
    parameter int POS_WIDTH        = 8,
    parameter int HOLD_CYCLES      = 2,
    parameter int GAP_CYCLES       = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                clock,
    input  logic                reset,
    pll_phase_stepper_if.slave  ctrl,
`ifdef PHASE_STEP_ABORT_EN
    input  logic                abort_req,
`endif
    output logic                pll_phasestep,
    output logic                pll_phaseupdown,
    output logic [2:0]          pll_phasecounterselect,
    input  logic                pll_phasedone
);

    localparam int CNT_MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state, state_next;
    logic                 pd_meta, pd_s;
    logic [CNT_W-1:0]     cnt;
    logic [15:0]          steps_left_q;
    logic [POS_WIDTH-1:0] pos_q;
    logic                 up_q;
    logic [2:0]           sel_q;
    logic                 error_q;
    logic                 zero_done_q;
    logic                 abort_now;
    logic                 hold_met, gap_met, timed_out;
    logic                 busy, done;

    // phasedone is idle-high, so the synchronizer resets to 1 to avoid a false "step in progress".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pd_meta <= 1'b1;
            pd_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking here so pd_s takes the old pd_meta; blocking would collapse the two flops into one.
            pd_meta <= pll_phasedone;
            pd_s    <= pd_meta;
        end
    end

`ifdef PHASE_STEP_ABORT_EN
    logic abort_pending;
    logic in_move;

    assign in_move   = (state == S_ASSERT) || (state == S_WAIT_DONE) || (state == S_GAP);
    assign abort_now = abort_pending || (abort_req && in_move);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            abort_pending <= 1'b0;
        else if (state == S_IDLE)
            abort_pending <= 1'b0;
        else if (abort_req && in_move)
            abort_pending <= 1'b1;
    end
`else
    assign abort_now = 1'b0;
`endif

    // Shared cycle counter: restarts on every state change, so it times hold, gap and timeout alike.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state_next != state || state == S_IDLE)
            cnt <= '0;
        else if (cnt != CNT_W'(CNT_MAX))
            cnt <= cnt + 1'b1;
    end

    assign hold_met  = (cnt >= CNT_W'(HOLD_CYCLES - 1));
    assign gap_met   = (cnt >= CNT_W'(GAP_CYCLES - 1));
    assign timed_out = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (ctrl.step_req && ctrl.step_count != 16'd0)
                    state_next = S_ASSERT;
            end
            S_ASSERT: begin
                if (hold_met && !pd_s)
                    state_next = S_WAIT_DONE;
                else if (timed_out)
                    state_next = S_ERROR;
            end
            S_WAIT_DONE: begin
                if (pd_s)
                    state_next = abort_now ? S_DONE : S_GAP;
                else if (timed_out)
                    state_next = S_ERROR;
            end
            S_GAP: begin
                if (abort_now)
                    state_next = S_DONE;
                else if (gap_met)
                    state_next = (steps_left_q == 16'd0) ? S_DONE : S_ASSERT;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pll_phasestep = 1'b0;
        busy          = 1'b0;
        done          = zero_done_q;
        unique case (state)
            S_ASSERT: begin
                pll_phasestep = 1'b1;
                busy          = 1'b1;
            end
            S_WAIT_DONE: busy = 1'b1;
            S_GAP:       busy = 1'b1;
            S_ERROR:     busy = 1'b1;
            S_DONE:      done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            steps_left_q <= '0;
            pos_q        <= '0;
            up_q         <= 1'b0;
            sel_q        <= '0;
            error_q      <= 1'b0;
            zero_done_q  <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;

            if (state == S_IDLE && ctrl.step_req) begin
                error_q <= 1'b0;
                if (ctrl.step_count == 16'd0) begin
                    zero_done_q <= 1'b1;
                end else begin
                    steps_left_q <= ctrl.step_count;
                    up_q         <= ctrl.step_up;
                    sel_q        <= ctrl.counter_sel;
                end
            end

            // A step counts only once the PLL has raised phasedone again.
            if (state == S_WAIT_DONE && pd_s) begin
                if (steps_left_q != 16'd0)
                    steps_left_q <= steps_left_q - 16'd1;
                if (up_q)
                    pos_q <= (pos_q == POS_WIDTH'(STEPS_PER_PERIOD - 1)) ? '0 : pos_q + 1'b1;
                else
                    pos_q <= (pos_q == '0) ? POS_WIDTH'(STEPS_PER_PERIOD - 1) : pos_q - 1'b1;
            end

            if (state_next == S_ERROR)
                error_q <= 1'b1;
        end
    end

    assign pll_phaseupdown        = up_q;
    assign pll_phasecounterselect = sel_q;

    assign ctrl.busy       = busy;
    assign ctrl.done       = done;
    assign ctrl.error      = error_q;
    assign ctrl.steps_left = steps_left_q;
    assign ctrl.phase_pos  = pos_q;

endmodule

// File: doc/pll_phase_stepper.md
Name: pll_phase_stepper

Overview:
- Downstream of the PMD Avalon register wrapper.
- Converts a phase-step request into the PLL dynamic phase-shift handshake (phasestep / phasedone) on the delayed modulation clock (mod_clk_delay).
- Supports multi-step moves, direction control, per-step timeout and a tracked phase position.
- Replaces the fixed-width PHASE_STEP pulse with a handshake that completes only after the PLL confirms each step.

Parameters:
- STEPS_PER_PERIOD, 64, number of PLL phase steps per modulation period; position wraps modulo this value.
- POS_WIDTH, 8, width of phase_pos; must satisfy 2^POS_WIDTH >= STEPS_PER_PERIOD.
- HOLD_CYCLES, 2, minimum clock cycles phasestep is held high per step.
- GAP_CYCLES, 4, idle clock cycles between consecutive steps.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait on any phasedone edge before aborting.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_req  in  1  single-cycle request; sampled only in IDLE.
- step_count  in  16  number of steps; captured on step_req.
- step_up  in  1  direction, 1 = advance phase; captured on step_req.
- counter_sel  in  3  PLL counter select; captured on step_req.
- busy  out  1  high from the cycle after an accepted step_req until DONE/ERROR is left.
- done  out  1  one-cycle pulse when all steps complete.
- error  out  1  sticky timeout flag.
- steps_left  out  16  remaining steps.
- phase_pos  out  POS_WIDTH  current tracked phase, 0..STEPS_PER_PERIOD-1.
- pll_phasestep  out  1  to PLL phasestep.
- pll_phaseupdown  out  1  to PLL phaseupdown.
- pll_phasecounterselect  out  3  to PLL phasecounterselect.
- pll_phasedone  in  1  from PLL; asynchronous, low while a step is in progress.

Behaviour:
- Reset values: all outputs 0; phase_pos 0; state IDLE. The pll_phasedone synchronizer resets to 1.
- pll_phasedone passes through a 2-flop synchronizer (pd_s). All decisions use pd_s, so there are 2 cycles of input latency.
- IDLE:
  - On step_req with step_count != 0: capture count, direction and counter select; clear error; go to ASSERT.
  - On step_req with step_count == 0: pulse done next cycle; stay idle; busy stays 0; error is cleared.
- ASSERT:
  - pll_phasestep = 1; pll_phaseupdown and pll_phasecounterselect hold the captured values from ASSERT entry until IDLE.
  - Leave when at least HOLD_CYCLES have elapsed and pd_s == 0; go to WAIT_DONE.
- WAIT_DONE:
  - pll_phasestep = 0.
  - When pd_s == 1: decrement steps_left; update phase_pos (+1 if up, -1 if down, modulo STEPS_PER_PERIOD: STEPS_PER_PERIOD-1 + 1 gives 0, and 0 - 1 gives STEPS_PER_PERIOD-1).
  - Then go to GAP.
- GAP:
  - Count GAP_CYCLES.
  - If steps_left == 0, go to DONE; otherwise go to ASSERT.
- DONE: done = 1 for exactly one cycle; busy drops in the same cycle; return to IDLE.
- Timeout:
  - One counter, cleared on entry to ASSERT and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES in ASSERT or WAIT_DONE: pll_phasestep = 0; error = 1 (sticky); phase_pos is not updated for the failed step; go to ERROR.
  - ERROR lasts one cycle, then IDLE; done is not pulsed.
- step_req while busy is ignored; no queuing.
- Reset mid-operation: pll_phasestep drops immediately (asynchronous); phase_pos returns to 0. Software must recalibrate the phase.
- steps_left is 16-bit unsigned with no underflow: it is only decremented when nonzero.

Optional Feature:
- Macro: PHASE_STEP_ABORT_EN.
- When defined, adds port abort_req (in, 1).
  - abort_req in ASSERT, WAIT_DONE or GAP sets a pending abort.
  - The in-flight step still completes its handshake and updates phase_pos.
  - The block then goes directly to DONE (done pulsed), with steps_left holding the unexecuted count.
  - abort_req in IDLE is ignored.
- When undefined: no abort port; every accepted request runs to completion or timeout.

Test Plan:
- PLL model (phasedone low 3 cycles after phasestep rises, high 5 cycles later); step_req with count=1, up=1 -> one phasestep pulse ≥2 cycles, done pulse, phase_pos=1, busy low after done.
- count=3, up=0 from phase_pos=0 -> three pulses separated by ≥GAP_CYCLES, phase_pos=63 then 62 then 61, single done, steps_left=0.
- 64 up-steps from 0 -> phase_pos wraps to 0; steps_left counts 64→0.
- PLL model never drops phasedone -> after 1024+sync cycles error=1, phasestep=0, no done, phase_pos unchanged; next step_req clears error.
- step_req asserted during busy, and step_req with count=0 -> busy-time request ignored (count unchanged); count=0 gives done one cycle after the request with no phasestep activity.
- Reset asserted while phasestep=1 -> phasestep=0 and phase_pos=0 immediately. With PHASE_STEP_ABORT_EN: abort during step 2 of 10 -> done after step 2 completes, phase_pos=2, steps_left=8.
